alu_issue_sequencer: RTL

- Multi-cycle issue/writeback engine that drives the combinational ALU from the other side of its interface.
- Accepts a 16-bit instruction over a valid/ready handshake and fetches three operands from the register file over two synchronous read ports.
- Presents instruction plus in0/in1/in2 to the ALU, captures the ALU result, writes it back to rd, and returns it on a valid/ready response channel.
- Sits between the fetch stage and the register file/ALU pair.

---
 rtl/alu_issue_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer
//   Multi-cycle issue/writeback engine sitting between the fetch stage and a
//   register file / combinational ALU pair. One instruction is in flight at a
//   time. Each instruction reads rs1, rs2 and rd, runs them through the ALU,
//   writes the result back to rd and returns it on a response channel.
//
//   Optional feature macro: ALU_SEQ_RETIRE_CNT_EN adds the retire_cnt output.
//   This is a 16-bit count of response handshakes.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   in_valid/in_ready       instruction handshake, in_inst = {op, rd, rs1, rs2}
//   rf_raddr0/1, rf_rdata0/1 register file reads (data one cycle after address)
//   rf_we/rf_waddr/rf_wdata  register file write port
//   alu_inst, alu_in0..2    ALU drive (rs1, rs2, rd values), alu_out result
//   out_valid/out_ready     response handshake, out_result = retired result
//   retire_cnt              (macro only) completed response handshakes
module alu_issue_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_inst,
    output logic [REG_AW-1:0] rf_raddr0,
    output logic [REG_AW-1:0] rf_raddr1,
    input  logic [DATA_W-1:0] rf_rdata0,
    input  logic [DATA_W-1:0] rf_rdata1,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [15:0]       alu_inst,
    output logic [DATA_W-1:0] alu_in0,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result
`ifdef ALU_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]       retire_cnt
`endif
);

    localparam int unsigned INST_W = 16;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_AB = 3'd1,
        RD_C  = 3'd2,
        EXEC  = 3'd3,
        WB    = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [INST_W-1:0]   inst_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   c_q;
    logic [DATA_W-1:0]   result_q;
    logic [REG_AW-1:0]   rd_addr;
    logic [REG_AW-1:0]   rs1_addr;
    logic [REG_AW-1:0]   rs2_addr;

    assign rd_addr  = REG_AW'(inst_q[11:8]);
    assign rs1_addr = REG_AW'(inst_q[7:4]);
    assign rs2_addr = REG_AW'(inst_q[3:0]);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded handshake / register file controls
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rf_raddr0 = '0;
        rf_raddr1 = '0;
        rf_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RD_AB;
            end
            RD_AB: begin
                rf_raddr0 = rs1_addr;
                rf_raddr1 = rs2_addr;
                state_d   = RD_C;
            end
            RD_C: begin
                rf_raddr0 = rd_addr;
                state_d   = EXEC;
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                // A reset arriving in this cycle must not leave a write behind.
                rf_we   = (rd_addr != '0) && reset_n;
                state_d = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Instruction latch, operand capture (r0 forced to zero) and result capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inst_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            result_q <= '0;
        end else begin
            if (state_q == IDLE && in_valid) inst_q <= in_inst;
            if (state_q == RD_C) begin
                a_q <= (rs1_addr == '0) ? '0 : rf_rdata0;
                b_q <= (rs2_addr == '0) ? '0 : rf_rdata1;
            end
            if (state_q == EXEC) c_q <= (rd_addr == '0) ? '0 : rf_rdata0;
            if (state_q == WB) result_q <= alu_out;
        end
    end

    assign alu_inst   = inst_q;
    assign alu_in0    = a_q;
    assign alu_in1    = b_q;
    assign alu_in2    = c_q;
    assign rf_waddr   = rd_addr;
    assign rf_wdata   = alu_out;
    assign out_result = result_q;

`ifdef ALU_SEQ_RETIRE_CNT_EN
    // Completed response handshakes, wrapping naturally at 16 bits
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            retire_cnt <= '0;
        end else if (state_q == RESP && out_ready) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
